// File: rtl/vmc_pkg.sv
// Shared types and address-map helpers for the vector memory controller.
package vmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        REG_INS,
        REG_ROM,
        REG_RAM,
        REG_SW,
        REG_NONE
    } region_t;

    // Base word address of a region in the global map; REG_NONE yields the
    // first address past the switch register file.
    function automatic int unsigned region_base(
        input region_t     r,
        input int unsigned ins_size,
        input int unsigned rom_size,
        input int unsigned ram_size,
        input int unsigned reg_count
    );
        case (r)
            REG_INS: return 0;
            REG_ROM: return ins_size;
            REG_RAM: return ins_size + rom_size;
            REG_SW:  return ins_size + rom_size + ram_size;
            default: return ins_size + rom_size + ram_size + reg_count;
        endcase
    endfunction

endpackage

// File: rtl/vmc_decode.sv
// Combinational address decoder: global word address -> region and
// region-relative offset.
module vmc_decode
    import vmc_pkg::*;
#(
    parameter int unsigned S         = 32,
    parameter int unsigned INS_SIZE  = 1000,
    parameter int unsigned ROM_SIZE  = 30000,
    parameter int unsigned RAM_SIZE  = 30000,
    parameter int unsigned REG_COUNT = 15
) (
    input  logic [S-1:0] addr,
    output region_t      region,
    output logic [S-1:0] offset
);

    localparam logic [S-1:0] ROM_BASE =
        S'(region_base(REG_ROM, INS_SIZE, ROM_SIZE, RAM_SIZE, REG_COUNT));
    localparam logic [S-1:0] RAM_BASE =
        S'(region_base(REG_RAM, INS_SIZE, ROM_SIZE, RAM_SIZE, REG_COUNT));
    localparam logic [S-1:0] SW_BASE  =
        S'(region_base(REG_SW, INS_SIZE, ROM_SIZE, RAM_SIZE, REG_COUNT));
    localparam logic [S-1:0] MAP_END  =
        S'(region_base(REG_NONE, INS_SIZE, ROM_SIZE, RAM_SIZE, REG_COUNT));

    // Regions are contiguous and ascending, so a priority compare chain suffices.
    always_comb begin
        region = REG_NONE;
        offset = '0;
        if (addr < ROM_BASE) begin
            region = REG_INS;
            offset = addr;
        end else if (addr < RAM_BASE) begin
            region = REG_ROM;
            offset = addr - ROM_BASE;
        end else if (addr < SW_BASE) begin
            region = REG_RAM;
            offset = addr - RAM_BASE;
        end else if (addr < MAP_END) begin
            region = REG_SW;
            offset = addr - SW_BASE;
        end
    end

endmodule

// File: rtl/vec_mem_ctrl.sv
// Vector/scalar memory controller: decodes a request against the global map,
// issues one word per cycle to ROM, RAM or the switch registers, gathers read
// lanes and returns a single held response.
module vec_mem_ctrl
    import vmc_pkg::*;
#(
    parameter int unsigned S         = 32,
    parameter int unsigned LANES     = 6,
    parameter int unsigned INS_SIZE  = 1000,
    parameter int unsigned ROM_SIZE  = 30000,
    parameter int unsigned RAM_SIZE  = 30000,
    parameter int unsigned REG_COUNT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic                   req_vec,
    input  logic [S-1:0]           req_addr,
    input  logic [S*LANES-1:0]     req_wd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [S*LANES-1:0]     rsp_rd,
    output logic                   rsp_err,
    output logic [S-1:0]           rom_addr,
    input  logic [S-1:0]           rom_rd,
    output logic [S-1:0]           ram_addr,
    output logic                   ram_we,
    output logic [S-1:0]           ram_wd,
    input  logic [S-1:0]           ram_rd,
    input  logic [S*REG_COUNT-1:0] switch_regs
);

    localparam int unsigned V  = S * LANES;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_t         state, state_nx;

    // Request decode (first and last word of the incoming request)
    logic [S:0]     last_sum;
    logic [S-1:0]   last_addr;
    region_t        first_reg, last_reg;
    logic [S-1:0]   first_off, last_off_unused;
    logic           req_err;
    logic           accept;

    // Latched request
    region_t        cur_reg;
    logic [S-1:0]   base_off;
    logic           cur_we;
    logic [V-1:0]   wd_q;
    logic [LW-1:0]  last_lane;
    logic           err_q;

    // Lane sequencing and read capture
    logic [LW-1:0]  lane;
    logic [S-1:0]   lane_addr;
    logic [S-1:0]   lane_wd;
    logic [S-1:0]   sw_word;
    logic           sw_cap;
    logic           pend;
    logic [LW-1:0]  pend_lane;

    vmc_decode #(
        .S         (S),
        .INS_SIZE  (INS_SIZE),
        .ROM_SIZE  (ROM_SIZE),
        .RAM_SIZE  (RAM_SIZE),
        .REG_COUNT (REG_COUNT)
    ) u_dec_first (
        .addr   (req_addr),
        .region (first_reg),
        .offset (first_off)
    );

    vmc_decode #(
        .S         (S),
        .INS_SIZE  (INS_SIZE),
        .ROM_SIZE  (ROM_SIZE),
        .RAM_SIZE  (RAM_SIZE),
        .REG_COUNT (REG_COUNT)
    ) u_dec_last (
        .addr   (last_addr),
        .region (last_reg),
        .offset (last_off_unused)
    );

    // Error classification of the incoming request; the extra sum bit catches
    // wrap-around of addr+N-1 instead of letting it alias low memory.
    always_comb begin
        last_sum  = {1'b0, req_addr} + (req_vec ? (S+1)'(LANES - 1) : '0);
        last_addr = last_sum[S-1:0];
        req_err   = last_sum[S]
                  || (first_reg == REG_INS)
                  || (last_reg == REG_INS)
                  || (first_reg != last_reg)
                  || (last_reg == REG_NONE)
                  || (req_we && (first_reg != REG_RAM));
    end

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = (state == ST_RESP) && err_q;
    assign lane_addr = base_off + S'(lane);
    assign sw_cap    = (state == ST_ISSUE) && (cur_reg == REG_SW) && !cur_we;

    // Select the write word and switch register addressed by the current lane.
    always_comb begin
        lane_wd = '0;
        sw_word = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (lane == LW'(j)) lane_wd = wd_q[S*j +: S];
        end
        for (int unsigned k = 0; k < REG_COUNT; k++) begin
            if (lane_addr == S'(k)) sw_word = switch_regs[S*k +: S];
        end
    end

    // Drive the memory ports only while issuing lanes to that region.
    always_comb begin
        rom_addr = '0;
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_wd   = '0;
        if (state == ST_ISSUE) begin
            case (cur_reg)
                REG_ROM: rom_addr = lane_addr;
                REG_RAM: begin
                    ram_addr = lane_addr;
                    ram_we   = cur_we;
                    ram_wd   = cur_we ? lane_wd : '0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; ROM/RAM reads need one DRAIN cycle for the last lane.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = req_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE: if (lane == last_lane)
                          state_nx = (cur_we || (cur_reg == REG_SW)) ? ST_RESP : ST_DRAIN;
            ST_DRAIN: state_nx = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Request latch, lane counter and response gathering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_reg   <= REG_NONE;
            base_off  <= '0;
            cur_we    <= 1'b0;
            wd_q      <= '0;
            last_lane <= '0;
            err_q     <= 1'b0;
            lane      <= '0;
            pend      <= 1'b0;
            pend_lane <= '0;
            rsp_rd    <= '0;
        end else begin
            // A ROM/RAM read issued this cycle returns data next cycle.
            pend      <= (state == ST_ISSUE) && !cur_we
                      && ((cur_reg == REG_ROM) || (cur_reg == REG_RAM));
            pend_lane <= lane;
            if (accept) begin
                cur_reg   <= first_reg;
                base_off  <= first_off;
                cur_we    <= req_we;
                wd_q      <= req_wd;
                last_lane <= req_vec ? LW'(LANES - 1) : '0;
                err_q     <= req_err;
                lane      <= '0;
                rsp_rd    <= '0;
            end else begin
                if (state == ST_ISSUE) lane <= lane + LW'(1);
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (pend && (pend_lane == LW'(j)))
                        rsp_rd[S*j +: S] <= (cur_reg == REG_ROM) ? rom_rd : ram_rd;
                    if (sw_cap && (lane == LW'(j)))
                        rsp_rd[S*j +: S] <= sw_word;
                end
            end
        end
    end

endmodule

// File: doc/vec_mem_ctrl.md
VEC_MEM_CTRL -- requirements
Module: vec_mem_ctrl

Interface
REQ-001 Parameter S, default 32, scalar word width in bits.
REQ-002 Parameter LANES, default 6, words per vector; V = S*LANES.
REQ-003 Parameter INS_SIZE, default 1000, instruction region words, base 0.
REQ-004 Parameter ROM_SIZE, default 30000, ROM words, base ROM_BASE = INS_SIZE.
REQ-005 Parameter RAM_SIZE, default 30000, RAM words, base RAM_BASE = ROM_BASE+ROM_SIZE.
REQ-006 Parameter REG_COUNT, default 15, switch registers, base REG_BASE = RAM_BASE+RAM_SIZE.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request
- req_we  in  1  1 = write, 0 = read
- req_vec  in  1  1 = LANES-word vector op, 0 = scalar (lane 0 only)
- req_addr  in  S  word address, global map
- req_wd  in  V  write data; lane i = bits [S*i +: S]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rd  out  V  read data; unused lanes zero
- rsp_err  out  1  request rejected, no memory access
- rom_addr  out  S  ROM word address, region-relative
- rom_rd  in  S  ROM data, one-cycle synchronous latency
- ram_addr  out  S  RAM word address, region-relative
- ram_we  out  1  RAM write strobe
- ram_wd  out  S  RAM write word
- ram_rd  in  S  RAM data, one-cycle synchronous latency
- switch_regs  in  REG_COUNT*S  switch register file; reg k = [S*k +: S]

Function
REQ-008 States SHALL be IDLE, ISSUE, DRAIN, RESP; req_ready = 1 only in IDLE.
REQ-009 On req_valid & req_ready the SHALL latch addr, we, vec and wd, and set N = vec ? LANES : 1.
REQ-010 Region decode SHALL use addr and addr+N-1. Error if either is in INS, they fall in different regions, addr+N-1 >= REG_BASE+REG_COUNT, the op writes ROM, or the op writes REG.
REQ-011 Error request: next state RESP with rsp_err=1 and rsp_rd=0; no ram_we and no lane issue.
REQ-012 ISSUE SHALL run N cycles; lane counter i goes 0..N-1; lane i drives addr-base+i on the region port in ISSUE cycle i.
REQ-013 RAM write: ram_we=1 and ram_wd=lane i of the latched wd for each ISSUE cycle; after the last lane, go to RESP. ram_we=0 in all other states.
REQ-014 ROM/RAM read: the word issued in ISSUE cycle i SHALL be captured into rsp_rd lane i at the end of the following cycle. After the last lane, DRAIN lasts one cycle to capture lane N-1, then RESP.
REQ-015 REG read: lane i = switch_regs word (addr-REG_BASE+i), captured combinationally in ISSUE cycle i; after the last lane, go straight to RESP (no DRAIN).
REQ-016 Latency, counted from the accept edge: RAM write rsp_valid at cycle N+1; ROM/RAM read at cycle N+2; REG read at cycle N+1; error at cycle 1.
REQ-017 RESP SHALL hold rsp_valid, rsp_rd and rsp_err stable until rsp_ready; on rsp_valid & rsp_ready, go to IDLE.
REQ-018 A new request is accepted no earlier than the cycle after the response handshake; req_valid outside IDLE is ignored.
REQ-019 Address arithmetic is S-bit unsigned. An addr+N-1 overflow SHALL be flagged as an error, never wrapped.

Reset
REQ-020 While rst=1: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rd=0, ram_we=0, ram_addr=rom_addr=ram_wd=0.
REQ-021 After rst deasserts: req_ready=1 in the first cycle.
REQ-022 rst mid-burst aborts immediately: no further ram_we and no response; lanes already written are not rolled back.

Structure
REQ-023 Package vmc_pkg SHALL hold the state enum, region enum (REG_INS, REG_ROM, REG_RAM, REG_SW, REG_NONE) and a base-address function of the size parameters.
REQ-024 Sub-module vmc_decode SHALL be combinational: address -> region and region-relative offset; instantiated twice (first and last word).

Verification
REQ-025 Scalar RAM write, addr 31000, wd lane0=0xDEADBEEF -> one ram_we at ram_addr 0; rsp_valid at cycle 2, rsp_err=0.
REQ-026 Vector ROM read, addr 1000, rom_rd = 0x100+address -> rsp_rd lanes 0x100..0x105; rsp_valid at cycle 8.
REQ-027 Vector read, addr 30998 (ROM/RAM straddle) -> rsp_err=1 at cycle 1, no port activity; same for write to 1500 and read of 61012 vector.
REQ-028 Vector read, addr 61000, switch_regs k = k+1 -> lanes 1..6; rsp_valid at cycle 7.
REQ-029 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rd stable, req_ready=0 throughout.
REQ-030 rst asserted in ISSUE cycle 3 of a vector RAM write -> exactly 3 ram_we pulses, no rsp_valid; req_ready=1 after release.
